section_scan_ctrl: RTL and testbench

//  Sequences one full-board threat scan through a single section_processor instance.
//  On start, fetches each board section (rows, columns, both diagonal directions) by index.
//  For each section it launches the processor, waits a fixed number of cycles, then

---
 rtl/c6_pkg.sv | 43 ++++
 rtl/section_scan_ctrl_if.sv | 29 ++
 rtl/sat_acc.sv | 34 +++
 rtl/section_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_section_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/c6_pkg.sv
// c6_pkg: shared constants and types for the board threat-scan controller.
//   - board section geometry (SECTION_SIZE, NUM_SECTIONS, IDX_W)
//   - scan FSM state encoding
//   - field order of sp_counts / totals: {T4_b,T3_b,T2_b,T4_w,T3_w,T2_w},
//     field 0 is the least significant slice
//   - threat score weights and helper (used when THREAT_SCORE_EN is defined)
package c6_pkg;

  localparam int SECTION_SIZE = 19;
  localparam int SECTION_W    = 2 * SECTION_SIZE;
  localparam int NUM_SECTIONS = 92;
  localparam int IDX_W        = 7;

  localparam int CNT_W        = 2;
  localparam int NUM_FIELDS   = 6;
  localparam int SP_COUNTS_W  = CNT_W * NUM_FIELDS;

  localparam int F_T2_W = 0;
  localparam int F_T3_W = 1;
  localparam int F_T4_W = 2;
  localparam int F_T2_B = 3;
  localparam int F_T3_B = 4;
  localparam int F_T4_B = 5;

  localparam int SCORE_W4 = 64;
  localparam int SCORE_W3 = 8;
  localparam int SCORE_W2 = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_ACCUM  = 3'd4,
    S_DONE   = 3'd5
  } scan_state_t;

  function automatic int score_of(input int t4b, input int t3b, input int t2b,
                                  input int t4w, input int t3w, input int t2w);
    return SCORE_W4 * (t4b - t4w) + SCORE_W3 * (t3b - t3w) + SCORE_W2 * (t2b - t2w);
  endfunction

endpackage

// File: rtl/section_scan_ctrl_if.sv
// section_scan_ctrl_if: section fetch bus plus section_processor link.
//   sec_req/sec_idx   : fetch request and section index (controller drives)
//   sec_valid/sec_data: fetched section cells, 2 bits/cell {b,w}, MSB pair = cell 0
//   sp_start          : one-cycle processor launch pulse
//   sp_section        : registered section presented to the processor
//   sp_counts         : per-section threat counts returned by the processor
// master = scan controller, slave = fetcher/processor side.
interface section_scan_ctrl_if;
  import c6_pkg::*;

  logic                   sec_req;
  logic [IDX_W-1:0]       sec_idx;
  logic                   sec_valid;
  logic [SECTION_W-1:0]   sec_data;
  logic                   sp_start;
  logic [SECTION_W-1:0]   sp_section;
  logic [SP_COUNTS_W-1:0] sp_counts;

  modport master (
    output sec_req, sec_idx, sp_start, sp_section,
    input  sec_valid, sec_data, sp_counts
  );

  modport slave (
    input  sec_req, sec_idx, sp_start, sp_section,
    output sec_valid, sec_data, sp_counts
  );

endinterface

// File: rtl/sat_acc.sv
// sat_acc: one saturating threat total.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over en)
//   en       : add addend this cycle
//   addend   : 2-bit per-section count
//   sum      : running total, sticks at 2**ACC_W-1
module sat_acc #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       addend,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] r_sum;
  logic [ACC_W:0]   w_wide;

  assign w_wide = {1'b0, r_sum} + {{(ACC_W-1){1'b0}}, addend};
  assign sum    = r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (clr) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= w_wide[ACC_W] ? '1 : w_wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/section_scan_ctrl.sv
// section_scan_ctrl: sequences one full-board threat scan through a single
// section_processor. For each of NUM_SECTIONS sections: fetch, launch the
// processor, wait SP_WAIT cycles, accumulate the six 2-bit threat counts
// into saturating totals.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle scan request, ignored while busy
//   abort    : synchronous abort back to IDLE (no done)
//   bus      : fetch + processor link (section_scan_ctrl_if.master)
//   busy     : high outside IDLE
//   done     : one-cycle completion pulse
//   totals   : {T4_b,T3_b,T2_b,T4_w,T3_w,T2_w}, ACC_W bits each, held after done
//   score    : (only with THREAT_SCORE_EN) signed weighted threat balance
// Optional feature macro: THREAT_SCORE_EN.
module section_scan_ctrl
  import c6_pkg::*;
#(
  parameter int SP_WAIT = 16,
  parameter int ACC_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  section_scan_ctrl_if.master    bus,
  output logic                   busy,
  output logic                   done,
  output logic [6*ACC_W-1:0]     totals
`ifdef THREAT_SCORE_EN
  ,
  output logic signed [ACC_W+6:0] score
`endif
);

  localparam int WAIT_W = (SP_WAIT > 1) ? $clog2(SP_WAIT) : 1;

  scan_state_t          r_state;
  scan_state_t          w_next;
  logic [IDX_W-1:0]     r_sec_idx;
  logic [WAIT_W-1:0]    r_wait;
  logic [SECTION_W-1:0] r_section;

  logic w_accept;
  logic w_last;
  logic w_acc_en;

  assign w_accept = (r_state == S_IDLE) && start && !abort;
  assign w_last   = (r_sec_idx == IDX_W'(NUM_SECTIONS - 1));
  assign w_acc_en = (r_state == S_ACCUM) && !abort;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next = S_FETCH;
        S_FETCH:  if (bus.sec_valid) w_next = S_LAUNCH;
        S_LAUNCH: w_next = S_WAIT;
        S_WAIT:   if (r_wait == '0) w_next = S_ACCUM;
        S_ACCUM:  w_next = w_last ? S_DONE : S_FETCH;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    bus.sec_req  = (r_state == S_FETCH);
    bus.sp_start = (r_state == S_LAUNCH);
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
  end

  assign bus.sec_idx    = r_sec_idx;
  assign bus.sp_section = r_section;

  // Section index, wait counter and processor input register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_idx <= '0;
      r_wait    <= '0;
      r_section <= '0;
    end else begin
      if (w_accept)
        r_sec_idx <= '0;
      else if (w_acc_en && !w_last)
        r_sec_idx <= r_sec_idx + 1'b1;

      if ((r_state == S_FETCH) && bus.sec_valid && !abort)
        r_section <= bus.sec_data;

      if (r_state == S_LAUNCH)
        r_wait <= WAIT_W'(SP_WAIT - 1);
      else if ((r_state == S_WAIT) && (r_wait != '0))
        r_wait <= r_wait - 1'b1;
    end
  end

  // One saturating total per sp_counts field, same slice order on both sides
  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_acc
    sat_acc #(.ACC_W(ACC_W)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_accept),
      .en     (w_acc_en),
      .addend (bus.sp_counts[CNT_W*g +: CNT_W]),
      .sum    (totals[ACC_W*g +: ACC_W])
    );
  end

`ifdef THREAT_SCORE_EN
  logic signed [ACC_W+6:0] r_score;
  logic signed [ACC_W+6:0] w_score;

  always_comb begin
    w_score = (ACC_W+7)'(score_of(int'(totals[F_T4_B*ACC_W +: ACC_W]),
                                  int'(totals[F_T3_B*ACC_W +: ACC_W]),
                                  int'(totals[F_T2_B*ACC_W +: ACC_W]),
                                  int'(totals[F_T4_W*ACC_W +: ACC_W]),
                                  int'(totals[F_T3_W*ACC_W +: ACC_W]),
                                  int'(totals[F_T2_W*ACC_W +: ACC_W])));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_score <= '0;
    else if (r_state == S_DONE) r_score <= w_score;
  end

  // Totals are final on entry to DONE but only get captured at its closing
  // edge, so the DONE cycle forwards the live value to keep score valid with done.
  assign score = (r_state == S_DONE) ? w_score : r_score;
`endif

endmodule

// File: tb/tb_section_scan_ctrl.sv
// Testbench for section_scan_ctrl: table of full-scan vectors plus hand
// sequences for idle abort/start, abort mid-scan, done-coincident start and
// asynchronous reset mid-scan. Define THREAT_SCORE_EN to also check score.
module tb_section_scan_ctrl;
  import c6_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [47:0] totals;
`ifdef THREAT_SCORE_EN
  logic signed [14:0] score;
`endif

  section_scan_ctrl_if bus();

  section_scan_ctrl #(.SP_WAIT(16), .ACC_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .totals (totals)
`ifdef THREAT_SCORE_EN
    ,
    .score  (score)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [37:0] data_for(input int idx);
    logic [63:0] v;
    v = 64'(idx) * 64'h9E37_79B9_7F4A_7C15;
    return v[63:26] ^ 38'h2A_AAAA_AAAA;
  endfunction

  // Fetcher / processor model
  logic [11:0] cnt_tab [NUM_SECTIONS];
  int   fetch_delay = 0;
  bit   junk_valid  = 1'b0;
  int   sp_starts   = 0;
  int   idx_err     = 0;
  int   sect_err    = 0;
  int   req_cnt;
  logic prev_req;
  logic [IDX_W-1:0] prev_idx;

  initial begin
    req_cnt       = 0;
    prev_req      = 1'b0;
    prev_idx      = '0;
    bus.sec_valid = 1'b0;
    bus.sec_data  = '0;
    bus.sp_counts = '0;
    forever begin
      @(negedge clk);
      if (bus.sec_req) req_cnt++;
      else             req_cnt = 0;
      bus.sec_valid = bus.sec_req ? (req_cnt > fetch_delay) : junk_valid;
      bus.sec_data  = data_for(int'(bus.sec_idx));
      bus.sp_counts = cnt_tab[int'(bus.sec_idx)];
      if (bus.sec_req && prev_req && (bus.sec_idx !== prev_idx)) idx_err++;
      if (bus.sp_start) begin
        sp_starts++;
        if (bus.sp_section !== data_for(int'(bus.sec_idx))) sect_err++;
      end
      prev_req = bus.sec_req;
      prev_idx = bus.sec_idx;
    end
  end

  typedef struct {
    int          a_idx;
    logic [11:0] a_cnt;
    int          b_idx;
    logic [11:0] b_cnt;
    logic [11:0] base;
    int          delay;
    bit          busy_starts;
    logic [47:0] exp_tot;
    int          exp_cyc;
    int          exp_score;
  } vec_t;

  vec_t vecs [7];

  task automatic run_scan(input int vi, input vec_t v);
    int  cyc;
    bit  got;
    for (int i = 0; i < NUM_SECTIONS; i++) cnt_tab[i] = v.base;
    cnt_tab[v.a_idx] = v.a_cnt;
    cnt_tab[v.b_idx] = v.b_cnt;
    fetch_delay = v.delay;
    junk_valid  = (v.delay != 0);
    sp_starts   = 0;
    idx_err     = 0;
    sect_err    = 0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 6000 && !got) begin
      @(negedge clk);
      cyc++;
      start = (v.busy_starts && busy && (cyc % 37 == 5));
      if (done) got = 1'b1;
    end
    if (!got) begin
      chk($sformatf("v%0d_done_timeout", vi), 0, 1);
      start = 1'b0;
      return;
    end
    chk($sformatf("v%0d_cycles", vi), cyc, v.exp_cyc);
    chk($sformatf("v%0d_totals", vi), totals, v.exp_tot);
    chk($sformatf("v%0d_sp_starts", vi), sp_starts, NUM_SECTIONS);
    chk($sformatf("v%0d_idx_stable_errs", vi), idx_err, 0);
    chk($sformatf("v%0d_sp_section_errs", vi), sect_err, 0);
`ifdef THREAT_SCORE_EN
    chk($sformatf("v%0d_score_at_done", vi), score, v.exp_score);
`endif
    // start coincident with done must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_done_one_cycle", vi), done, 0);
    chk($sformatf("v%0d_idle_after_done", vi), busy, 0);
    @(negedge clk);
    chk($sformatf("v%0d_no_restart", vi), busy, 0);
    chk($sformatf("v%0d_totals_held", vi), totals, v.exp_tot);
`ifdef THREAT_SCORE_EN
    chk($sformatf("v%0d_score_held", vi), score, v.exp_score);
`endif
  endtask

  initial begin
    int k;
    int dones;

    vecs[0] = '{0,  12'h000, 0,  12'h000, 12'h000, 0, 1'b0, 48'h0000_0000_0000, 1749, 0};
    vecs[1] = '{5,  12'h402, 5,  12'h402, 12'h000, 0, 1'b0, 48'h0100_0000_0002, 1749, 62};
    vecs[2] = '{0,  12'h300, 0,  12'h300, 12'h300, 0, 1'b0, 48'h00FF_0000_0000, 1749, 2040};
    vecs[3] = '{0,  12'h060, 0,  12'h060, 12'h060, 0, 1'b0, 48'h0000_5CB8_0000, 1749, -11684};
    vecs[4] = '{91, 12'hFFF, 91, 12'hFFF, 12'h000, 5, 1'b1, 48'h0303_0303_0303, 2209, 0};
    vecs[5] = '{91, 12'h004, 91, 12'h004, 12'h001, 0, 1'b0, 48'h0000_0000_015B, 1749, -99};
    vecs[6] = '{10, 12'h010, 20, 12'h200, 12'h000, 1, 1'b0, 48'h0002_0001_0000, 1841, -48};

    for (int i = 0; i < NUM_SECTIONS; i++) cnt_tab[i] = 12'h000;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy",       busy, 0);
    chk("rst_done",       done, 0);
    chk("rst_totals",     totals, 0);
    chk("rst_sec_req",    bus.sec_req, 0);
    chk("rst_sec_idx",    bus.sec_idx, 0);
    chk("rst_sp_start",   bus.sp_start, 0);
    chk("rst_sp_section", bus.sp_section, 0);
`ifdef THREAT_SCORE_EN
    chk("rst_score",      score, 0);
`endif

    // abort alone in IDLE, then start+abort together: nothing starts
    abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_req",  bus.sec_req, 0);

    for (int i = 0; i < 7; i++) run_scan(i, vecs[i]);

    // abort in WAIT of section 40
    for (int i = 0; i < NUM_SECTIONS; i++) cnt_tab[i] = 12'h001;
    fetch_delay = 0;
    junk_valid  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 3000 && !(bus.sp_start && bus.sec_idx == 7'd40)) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_sec40_timeout", (k < 3000), 1);
    @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",    busy, 0);
    chk("abort_sec_req", bus.sec_req, 0);
    chk("abort_partial_totals", totals, 48'h0000_0000_0028);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_totals_held", totals, 48'h0000_0000_0028);
    for (int i = 0; i < NUM_SECTIONS; i++) cnt_tab[i] = 12'h000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_totals_cleared", totals, 0);
    chk("restart_sec_idx",        bus.sec_idx, 0);
    chk("restart_sec_req",        bus.sec_req, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("restart_abort_busy", busy, 0);

    // asynchronous reset mid-scan
    for (int i = 0; i < NUM_SECTIONS; i++) cnt_tab[i] = 12'hFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    chk("pre_rst_totals_nonzero", (totals != 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",       busy, 0);
    chk("arst_done",       done, 0);
    chk("arst_sec_req",    bus.sec_req, 0);
    chk("arst_sp_start",   bus.sp_start, 0);
    chk("arst_sec_idx",    bus.sec_idx, 0);
    chk("arst_sp_section", bus.sp_section, 0);
    chk("arst_totals",     totals, 0);
`ifdef THREAT_SCORE_EN
    chk("arst_score",      score, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("arst_stays_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
